// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_pkg
// Purpose : Shared types for the SRAM access controller. Contains the request
//           operation encoding, the access FSM states, the wait-counter width
//           and the request priority helper.
// Revision: 1.0 - initial release
// ============================================================================
package sram_pkg;

    localparam int WAIT_W = 3;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_RD_CPU,
        OP_RD_PPU,
        OP_WR
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE
    } state_e;

    // Resolve simultaneous strobes: write beats PPU read beats CPU read.
    function automatic op_e sel_op(input logic rd_cpu, input logic rd_ppu, input logic wr);
        op_e op;
        op = OP_NONE;
        if (wr)
            op = OP_WR;
        else if (rd_ppu)
            op = OP_RD_PPU;
        else if (rd_cpu)
            op = OP_RD_CPU;
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sram_sat_counter
// Purpose : Saturating up-counter that sticks at all-ones.
// Ports   : clk     - clock
//           rst     - synchronous active-high reset (clears count)
//           i_clr   - synchronous clear
//           i_inc   - increment request
//           o_count - current count
// Revision: 1.0 - initial release
// ============================================================================
module sram_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_count <= '0;
        else if (i_inc && (r_count != '1))
            r_count <= r_count + WIDTH'(1);
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/sram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sram_access_ctrl
// Purpose : Converts per-cycle memory strobes from the PPU/CPU multiplexer into
//           timed asynchronous SRAM read/write cycles. Read results land in a
//           CPU latch or a PPU latch, each with a one-cycle valid pulse.
// Ports   : clk, reset (sync, active-high), ce (gates request acceptance)
//           mem_addr/mem_read_cpu/mem_read_ppu/mem_write/mem_din - requests
//           busy - access in flight, requests ignored while high
//           cpu_dout/cpu_valid, ppu_dout/ppu_valid - read latches + pulses
//           sram_addr, sram_dq_o, sram_dq_oe, sram_dq_i,
//           sram_ce_n, sram_oe_n, sram_we_n - SRAM pad interface
//           stat_cpu_rd/stat_ppu_rd/stat_wr - saturating completion counters,
//           present only when SRAM_ACCESS_STATS_EN is defined
// Config  : `define SRAM_ACCESS_STATS_EN to add the statistics counters.
// Revision: 1.0 - initial release
// ============================================================================
module sram_access_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W      = 22,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_read_cpu,
    input  logic              mem_read_ppu,
    input  logic              mem_write,
    input  logic [7:0]        mem_din,
    output logic              busy,
    output logic [7:0]        cpu_dout,
    output logic [7:0]        ppu_dout,
    output logic              cpu_valid,
    output logic              ppu_valid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
`ifdef SRAM_ACCESS_STATS_EN
    ,
    output logic [15:0]       stat_cpu_rd,
    output logic [15:0]       stat_ppu_rd,
    output logic [15:0]       stat_wr
`endif
);

    localparam logic [WAIT_W-1:0] c_WAIT = WAIT_W'(WAIT_STATES);

    state_e              r_state,     w_state_nxt;
    op_e                 r_op,        w_op_nxt;
    op_e                 w_req_op;
    logic [WAIT_W-1:0]   r_cnt,       w_cnt_nxt;
    logic                r_busy,      w_busy_nxt;
    logic [7:0]          r_cpu_dout,  w_cpu_dout_nxt;
    logic [7:0]          r_ppu_dout,  w_ppu_dout_nxt;
    logic                r_cpu_valid, w_cpu_valid_nxt;
    logic                r_ppu_valid, w_ppu_valid_nxt;
    logic [ADDR_W-1:0]   r_addr,      w_addr_nxt;
    logic [7:0]          r_dq_o,      w_dq_o_nxt;
    logic                r_dq_oe,     w_dq_oe_nxt;
    logic                r_ce_n,      w_ce_n_nxt;
    logic                r_oe_n,      w_oe_n_nxt;
    logic                r_we_n,      w_we_n_nxt;

    // Next-state and next-output logic. All outputs are registered, so this
    // block computes the value each register takes at the coming edge.
    always_comb begin
        w_req_op        = sel_op(mem_read_cpu, mem_read_ppu, mem_write);
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_cnt_nxt       = r_cnt;
        w_busy_nxt      = r_busy;
        w_cpu_dout_nxt  = r_cpu_dout;
        w_ppu_dout_nxt  = r_ppu_dout;
        w_cpu_valid_nxt = 1'b0;
        w_ppu_valid_nxt = 1'b0;
        w_addr_nxt      = r_addr;
        w_dq_o_nxt      = r_dq_o;
        w_dq_oe_nxt     = r_dq_oe;
        w_ce_n_nxt      = r_ce_n;
        w_oe_n_nxt      = r_oe_n;
        w_we_n_nxt      = r_we_n;

        case (r_state)
            S_IDLE: begin
                // Drops the pad driver one cycle after a write's WE rise
                // (the write hold window), unless a new write starts now.
                w_dq_oe_nxt = 1'b0;
                if (ce && (w_req_op != OP_NONE)) begin
                    w_op_nxt   = w_req_op;
                    w_addr_nxt = mem_addr;
                    w_cnt_nxt  = c_WAIT;
                    w_busy_nxt = 1'b1;
                    w_ce_n_nxt = 1'b0;
                    if (w_req_op == OP_WR) begin
                        w_state_nxt = S_WR_SETUP;
                        w_dq_o_nxt  = mem_din;
                        w_dq_oe_nxt = 1'b1;
                        w_we_n_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_RD;
                        w_oe_n_nxt  = 1'b0;
                    end
                end
            end

            S_RD: begin
                if (r_cnt == '0) begin
                    if (r_op == OP_RD_PPU) begin
                        w_ppu_dout_nxt  = sram_dq_i;
                        w_ppu_valid_nxt = 1'b1;
                    end else begin
                        w_cpu_dout_nxt  = sram_dq_i;
                        w_cpu_valid_nxt = 1'b1;
                    end
                    w_oe_n_nxt  = 1'b1;
                    w_ce_n_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - WAIT_W'(1);
                end
            end

            S_WR_SETUP: begin
                w_we_n_nxt  = 1'b0;
                w_state_nxt = S_WR_PULSE;
            end

            S_WR_PULSE: begin
                if (r_cnt == '0) begin
                    // dq_oe is intentionally left high here; IDLE clears it.
                    w_we_n_nxt  = 1'b1;
                    w_ce_n_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - WAIT_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_NONE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_cpu_dout  <= 8'h00;
            r_ppu_dout  <= 8'h00;
            r_cpu_valid <= 1'b0;
            r_ppu_valid <= 1'b0;
            r_addr      <= '0;
            r_dq_o      <= 8'h00;
            r_dq_oe     <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= w_busy_nxt;
            r_cpu_dout  <= w_cpu_dout_nxt;
            r_ppu_dout  <= w_ppu_dout_nxt;
            r_cpu_valid <= w_cpu_valid_nxt;
            r_ppu_valid <= w_ppu_valid_nxt;
            r_addr      <= w_addr_nxt;
            r_dq_o      <= w_dq_o_nxt;
            r_dq_oe     <= w_dq_oe_nxt;
            r_ce_n      <= w_ce_n_nxt;
            r_oe_n      <= w_oe_n_nxt;
            r_we_n      <= w_we_n_nxt;
        end
    end

    assign busy       = r_busy;
    assign cpu_dout   = r_cpu_dout;
    assign ppu_dout   = r_ppu_dout;
    assign cpu_valid  = r_cpu_valid;
    assign ppu_valid  = r_ppu_valid;
    assign sram_addr  = r_addr;
    assign sram_dq_o  = r_dq_o;
    assign sram_dq_oe = r_dq_oe;
    assign sram_ce_n  = r_ce_n;
    assign sram_oe_n  = r_oe_n;
    assign sram_we_n  = r_we_n;

`ifdef SRAM_ACCESS_STATS_EN
    logic w_wr_done;

    // A write completes on the edge that raises WE.
    assign w_wr_done = (r_state == S_WR_PULSE) && (r_cnt == '0);

    sram_sat_counter #(.WIDTH(16)) u_stat_cpu_rd (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (1'b0),
        .i_inc   (w_cpu_valid_nxt),
        .o_count (stat_cpu_rd)
    );

    sram_sat_counter #(.WIDTH(16)) u_stat_ppu_rd (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (1'b0),
        .i_inc   (w_ppu_valid_nxt),
        .o_count (stat_ppu_rd)
    );

    sram_sat_counter #(.WIDTH(16)) u_stat_wr (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (1'b0),
        .i_inc   (w_wr_done),
        .o_count (stat_wr)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_access_ctrl
// Purpose : Self-checking bench for sram_access_ctrl. Three instances with
//           WAIT_STATES = 0, 1 and 2 share one stimulus stream; a scoreboard
//           per instance holds expected read results and a monitor pops and
//           compares on every valid pulse. Timing is checked from per-instance
//           cycle counters kept by the monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sram_access_ctrl;

    localparam int N  = 3;
    localparam int AW = 22;

    typedef struct packed {
        logic       is_ppu;
        logic [7:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          ce;
    logic [AW-1:0] mem_addr;
    logic          mem_read_cpu;
    logic          mem_read_ppu;
    logic          mem_write;
    logic [7:0]    mem_din;
    logic [7:0]    sram_dq_i;

    logic          busy_a      [N];
    logic [7:0]    cpu_dout_a  [N];
    logic [7:0]    ppu_dout_a  [N];
    logic          cpu_valid_a [N];
    logic          ppu_valid_a [N];
    logic [AW-1:0] sram_addr_a [N];
    logic [7:0]    dq_o_a      [N];
    logic          dq_oe_a     [N];
    logic          ce_n_a      [N];
    logic          oe_n_a      [N];
    logic          we_n_a      [N];
`ifdef SRAM_ACCESS_STATS_EN
    logic [15:0]   st_cpu_a    [N];
    logic [15:0]   st_ppu_a    [N];
    logic [15:0]   st_wr_a     [N];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        sram_access_ctrl #(
            .ADDR_W      (AW),
            .WAIT_STATES (g)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .ce           (ce),
            .mem_addr     (mem_addr),
            .mem_read_cpu (mem_read_cpu),
            .mem_read_ppu (mem_read_ppu),
            .mem_write    (mem_write),
            .mem_din      (mem_din),
            .busy         (busy_a[g]),
            .cpu_dout     (cpu_dout_a[g]),
            .ppu_dout     (ppu_dout_a[g]),
            .cpu_valid    (cpu_valid_a[g]),
            .ppu_valid    (ppu_valid_a[g]),
            .sram_addr    (sram_addr_a[g]),
            .sram_dq_o    (dq_o_a[g]),
            .sram_dq_oe   (dq_oe_a[g]),
            .sram_dq_i    (sram_dq_i),
            .sram_ce_n    (ce_n_a[g]),
            .sram_oe_n    (oe_n_a[g]),
            .sram_we_n    (we_n_a[g])
`ifdef SRAM_ACCESS_STATS_EN
            ,
            .stat_cpu_rd  (st_cpu_a[g]),
            .stat_ppu_rd  (st_ppu_a[g]),
            .stat_wr      (st_wr_a[g])
`endif
        );
    end

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   acc_cyc;

    exp_t sb [N][$];
    exp_t mon_e;
    logic [7:0] m_cpu [N];
    logic [7:0] m_ppu [N];
    int   cnt_oe [N], cnt_busy [N], cnt_we [N], cnt_dqoe [N], vcyc [N];
    int   s_oe   [N], s_busy   [N], s_we   [N], s_dqoe   [N];
    logic [7:0] wdata [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d (WAIT_STATES=%0d): got %0h, expected %0h", name, k, k, act, exp);
        end
    endtask

    // Monitor / scoreboard consumer
    initial begin
        for (int k = 0; k < N; k++) begin
            cnt_oe[k] = 0; cnt_busy[k] = 0; cnt_we[k] = 0; cnt_dqoe[k] = 0;
            vcyc[k] = 0; wdata[k] = 8'h00; m_cpu[k] = 8'h00; m_ppu[k] = 8'h00;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (oe_n_a[k] === 1'b0) cnt_oe[k]++;
                if (busy_a[k] === 1'b1) cnt_busy[k]++;
                if (dq_oe_a[k] === 1'b1) cnt_dqoe[k]++;
                if (we_n_a[k] === 1'b0) begin
                    cnt_we[k]++;
                    wdata[k] = dq_o_a[k];
                end
                if (cpu_valid_a[k] === 1'b1 || ppu_valid_a[k] === 1'b1) begin
                    if (sb[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid dut%0d: got valid pulse, expected none", k);
                    end else begin
                        mon_e = sb[k].pop_front();
                        if (mon_e.is_ppu) m_ppu[k] = mon_e.data;
                        else              m_cpu[k] = mon_e.data;
                        vcyc[k] = cyc;
                        check("valid_class", k, {31'b0, ppu_valid_a[k]}, {31'b0, mon_e.is_ppu});
                        check("cpu_latch",   k, {24'b0, cpu_dout_a[k]}, {24'b0, m_cpu[k]});
                        check("ppu_latch",   k, {24'b0, ppu_dout_a[k]}, {24'b0, m_ppu[k]});
                    end
                end
                if (reset === 1'b1) begin
                    m_cpu[k] = 8'h00;
                    m_ppu[k] = 8'h00;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_all(input logic is_ppu, input logic [7:0] d);
        for (int k = 0; k < N; k++) sb[k].push_back({is_ppu, d});
    endtask

    task automatic issue(input logic c, input logic p, input logic w,
                         input logic [AW-1:0] a, input logic [7:0] d);
        for (int k = 0; k < N; k++) begin
            s_oe[k] = cnt_oe[k]; s_busy[k] = cnt_busy[k];
            s_we[k] = cnt_we[k]; s_dqoe[k] = cnt_dqoe[k];
        end
        mem_addr = a; mem_din = d;
        mem_read_cpu = c; mem_read_ppu = p; mem_write = w;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        mem_read_cpu = 1'b0; mem_read_ppu = 1'b0; mem_write = 1'b0;
    endtask

    // Stimulus
    initial begin
        reset = 1'b1; ce = 1'b1; mem_addr = '0; mem_din = 8'h00;
        mem_read_cpu = 1'b0; mem_read_ppu = 1'b0; mem_write = 1'b0;
        sram_dq_i = 8'h00;
        tick(3);
        for (int k = 0; k < N; k++) begin
            check("rst_busy",  k, {31'b0, busy_a[k]},  32'd0);
            check("rst_cpu",   k, {24'b0, cpu_dout_a[k]}, 32'd0);
            check("rst_ppu",   k, {24'b0, ppu_dout_a[k]}, 32'd0);
            check("rst_valid", k, {30'b0, cpu_valid_a[k], ppu_valid_a[k]}, 32'd0);
            check("rst_addr",  k, {10'b0, sram_addr_a[k]}, 32'd0);
            check("rst_ctl",   k, {28'b0, ce_n_a[k], oe_n_a[k], we_n_a[k], dq_oe_a[k]}, 32'hE);
        end
        reset = 1'b0;
        tick(2);

        // PPU read, data due WAIT_STATES+1 cycles after accept
        sram_dq_i = 8'hA5;
        push_all(1'b1, 8'hA5);
        issue(1'b0, 1'b1, 1'b0, 22'h000123, 8'h00);
        tick(12);
        for (int k = 0; k < N; k++) begin
            check("ppu_rd_latency", k, vcyc[k] - acc_cyc, k + 1);
            check("ppu_rd_oe_cyc",  k, cnt_oe[k] - s_oe[k], k + 1);
            check("ppu_rd_addr",    k, {10'b0, sram_addr_a[k]}, 32'h123);
        end

        // CPU read at top of address space
        sram_dq_i = 8'h3C;
        push_all(1'b0, 8'h3C);
        issue(1'b1, 1'b0, 1'b0, 22'h3FFFFF, 8'h00);
        tick(12);
        for (int k = 0; k < N; k++) begin
            check("cpu_rd_latency", k, vcyc[k] - acc_cyc, k + 1);
            check("cpu_rd_oe_cyc",  k, cnt_oe[k] - s_oe[k], k + 1);
            check("cpu_rd_busy",    k, cnt_busy[k] - s_busy[k], k + 1);
            check("cpu_rd_addr",    k, {10'b0, sram_addr_a[k]}, 32'h3FFFFF);
        end

        // Write: 1 setup cycle, WE low WAIT_STATES+1, dq_oe one cycle past WE rise
        sram_dq_i = 8'h00;
        issue(1'b0, 1'b0, 1'b1, 22'h000010, 8'h5A);
        tick(12);
        for (int k = 0; k < N; k++) begin
            check("wr_busy",   k, cnt_busy[k] - s_busy[k], k + 2);
            check("wr_we_cyc", k, cnt_we[k] - s_we[k], k + 1);
            check("wr_oe_cyc", k, cnt_dqoe[k] - s_dqoe[k], k + 3);
            check("wr_data",   k, {24'b0, wdata[k]}, 32'h5A);
            check("wr_addr",   k, {10'b0, sram_addr_a[k]}, 32'h10);
            check("wr_no_oe",  k, cnt_oe[k] - s_oe[k], 32'd0);
        end

        // All strobes at once -> write only; request during busy ignored
        sram_dq_i = 8'h77;
        issue(1'b1, 1'b1, 1'b1, 22'h000020, 8'hC3);
        mem_addr = 22'h000044;
        mem_read_cpu = 1'b1;
        tick(1);
        mem_read_cpu = 1'b0;
        tick(12);
        for (int k = 0; k < N; k++) begin
            check("prio_we_cyc",  k, cnt_we[k] - s_we[k], k + 1);
            check("prio_busy",    k, cnt_busy[k] - s_busy[k], k + 2);
            check("prio_wdata",   k, {24'b0, wdata[k]}, 32'hC3);
            check("prio_cpu_keep", k, {24'b0, cpu_dout_a[k]}, 32'h3C);
            check("prio_ppu_keep", k, {24'b0, ppu_dout_a[k]}, 32'hA5);
        end

        // Reset during WR_PULSE
        issue(1'b0, 1'b0, 1'b1, 22'h000030, 8'h11);
        tick(1);
        reset = 1'b1;
        tick(1);
        for (int k = 0; k < N; k++) begin
            check("rstwr_we_n",  k, {31'b0, we_n_a[k]}, 32'd1);
            check("rstwr_ce_n",  k, {31'b0, ce_n_a[k]}, 32'd1);
            check("rstwr_busy",  k, {31'b0, busy_a[k]}, 32'd0);
            check("rstwr_dq_oe", k, {31'b0, dq_oe_a[k]}, 32'd0);
            check("rstwr_latch", k, {16'b0, cpu_dout_a[k], ppu_dout_a[k]}, 32'd0);
        end
        reset = 1'b0;
        tick(3);

        // ce drops right after accept: read completes, held strobe not accepted
        sram_dq_i = 8'hE1;
        push_all(1'b1, 8'hE1);
        issue(1'b0, 1'b1, 1'b0, 22'h000055, 8'h00);
        ce = 1'b0;
        mem_read_cpu = 1'b1;
        tick(12);
        mem_read_cpu = 1'b0;
        ce = 1'b1;
        tick(2);
        for (int k = 0; k < N; k++) begin
            check("ce0_latency", k, vcyc[k] - acc_cyc, k + 1);
            check("ce0_busy",    k, cnt_busy[k] - s_busy[k], k + 1);
            check("ce0_cpu",     k, {24'b0, cpu_dout_a[k]}, 32'd0);
        end

`ifdef SRAM_ACCESS_STATS_EN
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        for (int k = 0; k < N; k++)
            check("stat_rst", k, {16'b0, st_cpu_a[k]}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            sram_dq_i = 8'(i + 1);
            push_all(1'b0, 8'(i + 1));
            issue(1'b1, 1'b0, 1'b0, 22'h000100, 8'h00);
            tick(6);
        end
        issue(1'b0, 1'b0, 1'b1, 22'h000101, 8'h42);
        tick(8);
        for (int k = 0; k < N; k++) begin
            check("stat_cpu", k, {16'b0, st_cpu_a[k]}, 32'd2);
            check("stat_ppu", k, {16'b0, st_ppu_a[k]}, 32'd0);
            check("stat_wr",  k, {16'b0, st_wr_a[k]},  32'd1);
        end
`endif

        for (int k = 0; k < N; k++)
            check("sb_drained", k, sb[k].size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
